// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory bundle for the two-port data memory arbiter.
// master = requesters plus memory model side, slave = arbiter side.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              m0_valid;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ready;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_valid;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ready;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output m0_valid, m0_we, m0_addr, m0_wdata,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_valid, m1_we, m1_addr, m1_wdata,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

  modport slave (
    input  m0_valid, m0_we, m0_addr, m0_wdata,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_valid, m1_we, m1_addr, m1_wdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two requesters sharing one data memory: grant, access, response = 3 cycles.
// Backpressure: ready is only offered in IDLE, so a held valid waits for the next free slot.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          busy
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_vld;
  logic              gnt_id;
  logic [1:0]        ready;
  logic [1:0]        rvalid;
  logic              mem_read;
  logic              mem_write;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    ready     = 2'b00;
    rvalid    = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_vld = bus.m0_valid | bus.m1_valid;
        // Pointer only matters under contention; a lone requester always wins.
        gnt_id  = (bus.m0_valid & bus.m1_valid) ? ptr_q : bus.m1_valid;
        if (gnt_vld) begin
          ready[gnt_id] = 1'b1;
          ptr_d         = ~gnt_id;
          req_d.id      = gnt_id;
          req_d.we      = gnt_id ? bus.m1_we    : bus.m0_we;
          req_d.addr    = gnt_id ? bus.m1_addr  : bus.m0_addr;
          req_d.wdata   = gnt_id ? bus.m1_wdata : bus.m0_wdata;
          state_d       = ACCESS;
        end
      end

      ACCESS: begin
        mem_write = req_q.we;
        mem_read  = ~req_q.we;
        rdata_d   = req_q.we ? '0 : bus.mem_rdata;
        state_d   = RESP;
      end

      RESP: begin
        rvalid[req_q.id] = 1'b1;
        state_d          = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Gating on rst keeps an aborted write out of memory on the reset edge itself.
  assign bus.m0_ready  = ready[0]  & ~rst;
  assign bus.m1_ready  = ready[1]  & ~rst;
  assign bus.m0_rvalid = rvalid[0] & ~rst;
  assign bus.m1_rvalid = rvalid[1] & ~rst;
  assign bus.m0_rdata  = rst ? '0 : rdata_q;
  assign bus.m1_rdata  = rst ? '0 : rdata_q;
  assign bus.mem_addr  = rst ? '0 : req_q.addr;
  assign bus.mem_wdata = rst ? '0 : req_q.wdata;
  assign bus.mem_write = mem_write & ~rst;
  assign bus.mem_read  = mem_read  & ~rst;
  assign busy          = (state_q != IDLE) & ~rst;

  a_mem_excl: assert property (@(posedge clk) !(mem_read && mem_write));
  a_ready_idle: assert property (@(posedge clk) (ready == 2'b00) || (state_q == IDLE));
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, word address width; 256 words.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port m0_valid  input  1  requester 0 (CPU load/store) request pending.
REQ-006 Port m0_we  input  1  requester 0: 1 = write, 0 = read.
REQ-007 Port m0_addr  input  ADDR_W  requester 0 word address.
REQ-008 Port m0_wdata  input  DATA_W  requester 0 write data.
REQ-009 Port m0_ready  output  1  requester 0 request accepted this cycle.
REQ-010 Port m0_rvalid  output  1  requester 0 response; one-cycle pulse.
REQ-011 Port m0_rdata  output  DATA_W  requester 0 read data; valid while m0_rvalid.
REQ-012 Ports m1_valid, m1_we, m1_addr, m1_wdata, m1_ready, m1_rvalid, m1_rdata: identical to REQ-005..011 for requester 1 (debug/DMA loader).
REQ-013 Port mem_addr  output  ADDR_W  data memory word address.
REQ-014 Port mem_wdata  output  DATA_W  data memory write data.
REQ-015 Port mem_write  output  1  data memory write enable; memory writes on the clk edge.
REQ-016 Port mem_read  output  1  data memory read enable.
REQ-017 Port mem_rdata  input  DATA_W  data memory combinational read data.
REQ-018 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 Three-state FSM: IDLE, ACCESS, RESP; exactly one state is active at any time.
REQ-020 IDLE: if no valid is asserted, remain in IDLE with all ready, rvalid, mem_read and mem_write outputs low.
REQ-021 IDLE with one or more valids: grant exactly one requester.
  - Assert that requester's ready combinationally in the same cycle.
  - Latch its we, addr, wdata and the grant id.
  - Move to ACCESS.
REQ-022 Arbitration is round-robin on a 1-bit priority pointer.
  - Both valid: grant the pointer's requester.
  - One valid: grant it regardless of the pointer.
  - After every grant: pointer = inverse of the granted id.
REQ-023 ACCESS, one cycle:
  - mem_addr/mem_wdata are driven from the latched values.
  - Write: mem_write = 1, mem_read = 0.
  - Read: mem_read = 1, mem_write = 0, and mem_rdata is registered into the response register.
  - Move to RESP.
REQ-024 RESP, one cycle: pulse the granted requester's rvalid, then move to IDLE.
  - rdata carries the registered read data; for writes rdata is 0.
  - The other requester's rvalid stays 0.
REQ-025 Latency: accept (ready) at cycle T, memory access at T+1, rvalid at T+2; a new grant is possible at T+3; peak throughput is one transaction per 3 cycles.
REQ-026 ready is never asserted outside IDLE. valid held high across ACCESS and RESP is not accepted until the next IDLE cycle.
REQ-027 Requester inputs are sampled only in the grant cycle; changes afterwards do not affect the in-flight transaction.
REQ-028 Outside ACCESS: mem_write = 0 and mem_read = 0. mem_addr and mem_wdata hold their last latched values.
REQ-029 Address arithmetic: addr is passed through unmodified, ADDR_W bits wide; there is no byte-to-word conversion and no wrap logic in this block.
REQ-030 m0_rdata and m1_rdata are both driven from the single response register; consumers qualify it with their own rvalid.

Reset
REQ-031 While rst = 1 at a clk edge:
  - State = IDLE and the pointer selects requester 0.
  - Latched request fields and the response register = 0.
REQ-032 During and after reset, until the next grant, all outputs are 0 (ready, rvalid, rdata, mem_*, busy).
REQ-033 Reset in ACCESS or RESP aborts the transaction:
  - No rvalid is issued.
  - A write aborted in ACCESS at the reset edge is not committed, because mem_write is forced to 0 combinationally while rst = 1.

Verification
REQ-034 Single read: mem[5] = 0x1234, m0 read addr 5 at cycle T -> m0_ready at T, mem_read = 1 with mem_addr = 5 at T+1, m0_rvalid = 1 with m0_rdata = 0x1234 at T+2, busy at T+1..T+2.
REQ-035 Write then read: m1 writes 0xDEADBEEF to addr 0xFF -> mem_write pulse exactly one cycle; a later m1 read of addr 0xFF returns 0xDEADBEEF.
REQ-036 Contention: m0 and m1 valid continuously from reset -> grants alternate 0, 1, 0, 1; each rvalid goes only to its owner; ready is never high in two consecutive cycles.
REQ-037 Late valid: m1 raises valid while m0 is in ACCESS -> m1 is granted at the next IDLE cycle; m0's response is unaffected.
REQ-038 Reset mid-write: m0 write 0x55 to addr 3 (mem[3] = 0x11), rst asserted in ACCESS -> mem[3] stays 0x11, no m0_rvalid; after reset, the first contended grant goes to m0.
REQ-039 Idle: no valids for 20 cycles -> all outputs stay 0, busy = 0, the pointer is unchanged.
